uart_frame_scheduler: RTL

Sequences game-state telemetry onto the shared 16-bit UART word path, ahead of the 16-to-8 converter. It emits one coherent frame of tagged words per frame period. A match-control word is pre-empted into the stream whenever scores or flags change. It replaces free-running selector rotation with a frame timer, valid/ready handshake, snapshotting and overrun accounting.

---
 rtl/uart_frame_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler
// Description : Sequences game-state telemetry into tagged 16-bit words
//               {tag[3:0], payload[11:0]} for the 16-to-8 UART converter.
//               Emits one snapshotted frame per frame period. A match-control
//               word is inserted whenever scores or flags change. Uses a
//               valid/ready handshake and counts dropped frame ticks.
//               Optional macro UART_SCHED_CHECKSUM_EN appends a checksum word
//               (tag 0xF) to each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler #(
  parameter int FRAME_CYCLES = 1083333,
  parameter int CNT_W        = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  input  logic        whistle,
  input  logic        word_ready,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

  localparam logic [3:0] TAG_CTRL      = 4'h0;
  localparam logic [3:0] TAG_PL1_POSX  = 4'h3;
  localparam logic [3:0] TAG_PL1_POSY  = 4'h4;
  localparam logic [3:0] TAG_BALL_POSX = 4'h5;
  localparam logic [3:0] TAG_BALL_POSY = 4'h6;

  localparam logic [2:0] SLOT_CTRL = 3'd0;
`ifdef UART_SCHED_CHECKSUM_EN
  localparam logic [3:0] TAG_CKSUM = 4'hF;
  localparam logic [2:0] SLOT_LAST = 3'd5;
`else
  localparam logic [2:0] SLOT_LAST = 3'd4;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic             tick;
  logic             tick_pending;
  logic             inserted;      // current word is an inserted CTRL word
  logic [2:0]       slot;          // last scheduled slot presented
  logic [2:0]       slot_nxt;
  logic [11:0]      last_ctrl;
  logic [11:0]      ctrl;
  logic             pending_ctrl;
  logic             xfer;
  logic [15:0]      next_word;
  logic [11:0]      snap_pl1_posx;
  logic [11:0]      snap_pl1_posy;
  logic [11:0]      snap_ball_posx;
  logic [11:0]      snap_ball_posy;

  assign ctrl         = {1'b0, whistle, end_game, flag_point, pl2_score, pl1_score};
  assign pending_ctrl = (ctrl != last_ctrl);
  assign tick         = (frame_cnt == LAST_CNT);
  assign xfer         = data_valid & word_ready;
  assign slot_nxt     = slot + 3'd1;

`ifdef UART_SCHED_CHECKSUM_EN
  // Checksum covers the scheduled payloads only, so the scheduled CTRL
  // payload is kept alongside the position snapshot.
  logic [11:0] snap_ctrl;
  logic [11:0] cksum;
  assign cksum = snap_ctrl + snap_pl1_posx + snap_pl1_posy
               + snap_ball_posx + snap_ball_posy;
`endif

  // Free-running frame timer; its wrap cycle is the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Word selected for the scheduled slot following the current one.
  always_comb begin
    next_word = {TAG_CTRL, ctrl};
    case (slot_nxt)
      3'd1:    next_word = {TAG_PL1_POSX,  snap_pl1_posx};
      3'd2:    next_word = {TAG_PL1_POSY,  snap_pl1_posy};
      3'd3:    next_word = {TAG_BALL_POSX, snap_ball_posx};
      3'd4:    next_word = {TAG_BALL_POSY, snap_ball_posy};
`ifdef UART_SCHED_CHECKSUM_EN
      3'd5:    next_word = {TAG_CKSUM, cksum};
`endif
      default: next_word = {TAG_CTRL, ctrl};
    endcase
  end

  // Frame sequencer: snapshot, handshake, CTRL insertion and tick accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      data           <= '0;
      data_valid     <= 1'b0;
      busy           <= 1'b0;
      overrun_cnt    <= '0;
      tick_pending   <= 1'b0;
      last_ctrl      <= '0;
      inserted       <= 1'b0;
      slot           <= SLOT_CTRL;
      snap_pl1_posx  <= '0;
      snap_pl1_posy  <= '0;
      snap_ball_posx <= '0;
      snap_ball_posy <= '0;
`ifdef UART_SCHED_CHECKSUM_EN
      snap_ctrl      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick || tick_pending) begin
            snap_pl1_posx  <= pl1_posx;
            snap_pl1_posy  <= pl1_posy;
            snap_ball_posx <= ball_posx;
            snap_ball_posy <= ball_posy;
`ifdef UART_SCHED_CHECKSUM_EN
            snap_ctrl      <= ctrl;
`endif
            // Starting consumes one tick; a coincident second one stays queued.
            tick_pending   <= tick & tick_pending;
            state          <= ST_SEND;
            slot           <= SLOT_CTRL;
            inserted       <= 1'b0;
            busy           <= 1'b1;
            data_valid     <= 1'b1;
            data           <= {TAG_CTRL, ctrl};
          end else if (pending_ctrl) begin
            // Stand-alone CTRL word outside a frame; busy stays low.
            state      <= ST_SEND;
            inserted   <= 1'b1;
            data_valid <= 1'b1;
            data       <= {TAG_CTRL, ctrl};
          end
        end

        ST_SEND: begin
          if (tick) begin
            if (!tick_pending) begin
              tick_pending <= 1'b1;
            end else if (overrun_cnt != 8'hFF) begin
              overrun_cnt <= overrun_cnt + 8'd1;
            end
          end

          if (xfer) begin
            if (data[15:12] == TAG_CTRL) begin
              last_ctrl <= data[11:0];
            end

            if (inserted && !busy) begin
              state      <= ST_IDLE;
              inserted   <= 1'b0;
              data_valid <= 1'b0;
            end else if (!inserted && (slot != SLOT_CTRL) && (slot != SLOT_LAST)
                         && pending_ctrl) begin
              inserted <= 1'b1;
              data     <= {TAG_CTRL, ctrl};
            end else if (!inserted && (slot == SLOT_LAST)) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              data_valid <= 1'b0;
            end else begin
              slot     <= slot_nxt;
              inserted <= 1'b0;
              data     <= next_word;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
